// File: rtl/joypad_port.sv
// joypad_port: bus-mapped scanner for two NES-style serial pads (latch/clock/data).
// Define JOYPAD_DEBOUNCE_EN to commit a button change only after two matching scans.
module joypad_port #(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic       cs,
  input  logic       rw,
  input  logic [7:0] di,
  output logic [7:0] dout,
  input  logic       vsync,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic [1:0] pad_data
);

  localparam logic [8:0] LastLatch = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] LastHalf  = 9'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StLow, StHigh, StDone} state_e;

  state_e          state_q;
  logic [8:0]      cnt_q;
  logic [2:0]      idx_q;
  logic [1:0][7:0] shift_q;
  logic [1:0][7:0] btn_q;
  logic [1:0][7:0] edge_q;
  logic [7:0]      frames_q;
  logic            auto_q;
  logic            vsync_q;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [1:0][7:0] prev_raw_q;
`endif

  logic            busy, wr_en, trig_wr, rise, trigger;
  logic [1:0][7:0] pressed, commit_mask, edge_set, edge_clr;

  assign busy    = (state_q != StIdle);
  assign wr_en   = cs & rw;
  assign trig_wr = wr_en & (addr == 4'h4) & di[1];
  assign rise    = vsync & ~vsync_q;
  // Triggers seen while a scan is running are dropped, not queued.
  assign trigger = ~busy & ((auto_q & rise) | trig_wr);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pressed[p] = ~shift_q[p];
`ifdef JOYPAD_DEBOUNCE_EN
      commit_mask[p] = ~(pressed[p] ^ prev_raw_q[p]);
`else
      commit_mask[p] = 8'hFF;
`endif
      edge_set[p] = (state_q == StDone) ? (pressed[p] & ~btn_q[p] & commit_mask[p]) : 8'h00;
      edge_clr[p] = (wr_en && addr == {3'b001, p[0]}) ? di : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      btn_q     <= '0;
      edge_q    <= '0;
      frames_q  <= '0;
      auto_q    <= 1'b1;
      vsync_q   <= 1'b0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
      prev_raw_q <= '0;
`endif
    end else begin
      vsync_q <= vsync;
      if (wr_en && addr == 4'h4) auto_q <= di[0];
      // A flag set by this cycle's commit survives a coincident W1C write.
      for (int p = 0; p < 2; p++) edge_q[p] <= (edge_q[p] & ~edge_clr[p]) | edge_set[p];

      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            state_q   <= StLatch;
            cnt_q     <= '0;
            pad_latch <= 1'b1;
          end
        end
        StLatch: begin
          if (cnt_q == LastLatch) begin
            state_q   <= StLow;
            cnt_q     <= '0;
            idx_q     <= '0;
            pad_latch <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        StLow: begin
          if (cnt_q == LastHalf) begin
            cnt_q <= '0;
            shift_q[0][idx_q] <= pad_data[0];
            shift_q[1][idx_q] <= pad_data[1];
            if (idx_q == 3'd7) begin
              state_q <= StDone;
            end else begin
              state_q <= StHigh;
              pad_clk <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        StHigh: begin
          if (cnt_q == LastHalf) begin
            state_q <= StLow;
            cnt_q   <= '0;
            idx_q   <= idx_q + 3'd1;
            pad_clk <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        StDone: begin
          state_q  <= StIdle;
          frames_q <= frames_q + 8'd1;
          for (int p = 0; p < 2; p++) begin
            btn_q[p] <= (btn_q[p] & ~commit_mask[p]) | (pressed[p] & commit_mask[p]);
          end
`ifdef JOYPAD_DEBOUNCE_EN
          prev_raw_q <= pressed;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    dout = 8'h00;
    if (cs && !rw) begin
      case (addr)
        4'h0:    dout = btn_q[0];
        4'h1:    dout = btn_q[1];
        4'h2:    dout = edge_q[0];
        4'h3:    dout = edge_q[1];
        4'h4:    dout = {5'b00000, busy, 1'b0, auto_q};
        4'h5:    dout = frames_q;
        default: dout = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/joypad_port.md
Name: joypad_port

Overview:
- Memory-mapped bus responder for two serial game pads (NES-style latch/clock/data shift registers).
- Scans both pads once per frame on the vsync rising edge, or on demand, and exposes button state, sticky newly-pressed flags, control and a scan counter to the bus master.
- Decoded at 16'hEFE0–16'hEFEF; the address decoder drives cs, and the bus presents addr[3:0], rw (1 = write, 0 = read), di and dout.

Parameters:
CLK_DIV, 6, half-period of pad_clk and unit time of the scan, in clk cycles; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
addr  input  4  register select.
cs  input  1  chip select from the address decoder.
rw  input  1  1 = write, 0 = read.
di  input  8  write data.
dout  output  8  read data.
vsync  input  1  frame sync from the LCD timing block; level, high during blanking.
pad_latch  output  1  parallel-load strobe to both pads, active high.
pad_clk  output  1  shift clock to both pads.
pad_data  input  2  serial data; bit n is pad n; active low (0 = pressed).

Behaviour:
Register map (unlisted addresses read 8'h00; writes to them are ignored):
- 0x0 STATE0 (RO): committed buttons of pad 0, 1 = pressed; bit i is the i-th bit shifted.
- 0x1 STATE1 (RO): same for pad 1.
- 0x2 EDGE0 (W1C): sticky flags, set when a bit goes 0->1 in STATE0. Writing 1 to a bit clears it.
- 0x3 EDGE1 (W1C): same for pad 1.
- 0x4 CTRL:
  - bit0 AUTO (R/W), reset value 1.
  - bit1 TRIG: write 1 to request a scan; self-clearing; always reads 0.
  - bit2 BUSY (RO).
  - bits 7:3 read 0.
- 0x5 FRAMES (RO): count of completed scans; 8-bit, wraps 255->0.

Bus timing:
- dout is combinational: register[addr] when cs & ~rw, otherwise 8'h00. Reads have no side effects.
- A write takes effect at the posedge where cs & rw is high.

Trigger:
- vsync_q is a register holding vsync delayed one cycle. rise = vsync & ~vsync_q.
- A trigger fires when (AUTO & rise) or a TRIG write occurs in IDLE. The FSM enters LATCH at the next edge.
- Triggers arriving while BUSY are dropped; they are not queued.

Scan FSM, with D = CLK_DIV:
- IDLE: pad_latch = 0, pad_clk = 0.
- LATCH: pad_latch = 1 for 2D cycles, then go to LOW with bit index = 0.
- LOW: pad_clk = 0 for D cycles. On the last cycle, pad_data is sampled into shift bit [index] for each pad.
  - If index == 7, go to DONE.
  - Otherwise go to HIGH.
- HIGH: pad_clk = 1 for D cycles, then index++ and go to LOW.
- DONE: 1 cycle. Commit, then return to IDLE.
- Total scan: 17D cycles plus 1 DONE cycle (103 cycles at D = 6).
- BUSY = 1 in every state except IDLE.

Commit (DONE cycle), per pad:
- new = ~shift.
- EDGE |= new & ~STATE.
- STATE <= new.
- FRAMES <= FRAMES + 1.
- If a W1C write to EDGE coincides with the commit, a flag set by this commit wins; other written bits are cleared.

Reset (synchronous, honoured mid-scan):
- FSM returns to IDLE; pad_latch = 0, pad_clk = 0.
- STATE, EDGE and FRAMES = 0; AUTO = 1; vsync_q = 0; dout follows its combinational rule.
- A partial scan is discarded; no commit.

Optional Feature:
JOYPAD_DEBOUNCE_EN
- Defined: a per-pad 8-bit prev_raw register holds the previous scan's new value. In DONE, only bits where new == prev_raw update STATE and EDGE; prev_raw <= new every scan. A press must therefore appear in two consecutive scans to be committed. prev_raw resets to 0. FRAMES still increments every scan.
- Undefined: every scan commits directly, as described above.

Test Plan:
- Reset, then idle with no stimulus: pad_latch = 0, pad_clk = 0; reads at 0x0–0x5 return 00,00,00,00,01,00.
- D = 6, pad0 drives bits 10110101 active-low (bit0 first), pad1 all released; raise vsync:
  - pad_latch is high 12 cycles starting one cycle after the rise;
  - pad_clk shows 7 pulses of 6 cycles each;
  - 103 cycles after LATCH entry: STATE0 = 8'hAD, STATE1 = 00, EDGE0 = 8'hAD, FRAMES = 1.
- Write EDGE0 = 8'h0F: EDGE0 reads 8'hA0. A W1C write coinciding with a DONE that newly sets bit0: bit0 reads 1.
- AUTO = 0 (write CTRL = 00): a vsync rise causes no scan. Write CTRL = 02: scan runs and BUSY reads 1 during it. A second vsync rise or TRIG write mid-scan: FRAMES increments by exactly 1.
- Assert reset during HIGH of bit 3: the next cycle shows pad_clk = 0 and IDLE, and STATE and FRAMES = 0. A new trigger then runs a full clean scan.
- JOYPAD_DEBOUNCE_EN defined: button 2 is pressed for one scan only, so STATE0 stays 00. It is held for two scans, so STATE0 = 04 after the second scan. FRAMES = 3 after three scans.
